// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the LED matrix controller and row shifter.
package led_matrix_pkg;

  // Panel geometry.
  localparam int unsigned LM_COLS  = 32;
  localparam int unsigned LM_ROW_W = 3;
  localparam int unsigned LM_COL_W = 5;
  localparam int unsigned LM_RGB_W = 6;

  // Matrix controller timing: CE leads clk_en by this many cycles, and
  // drops this many cycles before the end of the shift window.
  localparam int unsigned CTRL_CE_LEAD = 2;
  localparam int unsigned CTRL_CE_TAIL = 2;

  // Row shifter FSM.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_END = 2'd2
  } shifter_state_e;

  // Panel pin order, MSB first: upper half-panel R1/G1/B1, lower R0/G0/B0.
  typedef struct packed {
    logic r1;
    logic g1;
    logic b1;
    logic r0;
    logic g0;
    logic b0;
  } rgb_t;

  // Column counter increment that wraps at the last column and never
  // carries into the row field of the framebuffer address.
  function automatic logic [LM_COL_W-1:0] col_next(
    input logic [LM_COL_W-1:0] col,
    input logic [LM_COL_W-1:0] last
  );
    return (col == last) ? '0 : col + LM_COL_W'(1);
  endfunction

endpackage

// File: rtl/led_row_shifter_if.sv
// Framebuffer read port: address/strobe out, data back one cycle later.
interface led_row_shifter_if
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROW_W = LM_ROW_W
);

  localparam int unsigned AW = 1 + ROW_W + LM_COL_W;

  logic                fb_rd_en;
  logic [AW-1:0]       fb_rd_addr;
  logic [LM_RGB_W-1:0] fb_rd_data;

  // Row shifter side: issues reads.
  modport master (
    output fb_rd_en,
    output fb_rd_addr,
    input  fb_rd_data
  );

  // Framebuffer side: answers reads.
  modport slave (
    input  fb_rd_en,
    input  fb_rd_addr,
    output fb_rd_data
  );

endinterface

// File: rtl/led_sclk_gate.sv
// Panel shift-clock gate: SCLK is high during the low phase of clk in
// enabled cycles. Kept alone so it can be swapped for a clock-gate/ODDR cell.
module led_sclk_gate (
  input  logic clk_i,
  input  logic en_i,
  output logic sclk_o
);

  // en_i comes from registered state and inputs launched on the rising
  // edge, so it is settled before clk falls and the pulse is clean.
  assign sclk_o = ~clk_i & en_i;

endmodule

// File: rtl/led_row_shifter.sv
// Row shifter for a HUB75-style panel: fetches one row from the framebuffer
// on CE rise, streams it onto rgb one column per clk_en cycle, generates
// SCLK, and switches framebuffer banks only at the end of a frame.
module led_row_shifter
  import led_matrix_pkg::*;
#(
  parameter int unsigned COLS  = LM_COLS,
  parameter int unsigned ROW_W = LM_ROW_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CE,
  input  logic                 clk_en,
  input  logic                 LAT,
  input  logic [ROW_W-1:0]     row_addr,
  input  logic                 swap_req,
  led_row_shifter_if.master    fb,
  output logic [LM_RGB_W-1:0]  rgb,
  output logic                 SCLK,
  output logic                 swap_ack,
  output logic                 overrun
);

  localparam int unsigned         SH_W     = LM_COL_W + 1;
  localparam logic [LM_COL_W-1:0] COL_LAST = LM_COL_W'(COLS - 1);
  localparam logic [SH_W-1:0]     SH_FULL  = SH_W'(COLS);
  localparam logic [ROW_W-1:0]    ROW_LAST = '1;

  shifter_state_e      state_q, state_d;
  logic                ce_q;
  logic [LM_COL_W-1:0] col_q, col_d;
  logic [SH_W-1:0]     sh_q, sh_d;
  logic                bank_q, bank_d;
  logic                pend_q, pend_d;
  logic                rd_en_q;
  logic                ack_q, ack_d;
  logic                ovr_q, ovr_d;
  rgb_t                rgb_q, rgb_d;

  logic                ce_rise;
  logic                rd_en;
  logic                in_row;
  logic                shift_ok;
  logic                over_cycle;
  logic                swap_now;

  assign ce_rise    = CE & ~ce_q;
  assign in_row     = (state_q != IDLE);
  assign shift_ok   = clk_en & in_row & (sh_q < SH_FULL);
  assign over_cycle = clk_en & in_row & (sh_q == SH_FULL);
  assign swap_now   = LAT & (row_addr == ROW_LAST) & (pend_q | swap_req);

  // Fetch FSM: one read per cycle from CE rise through the last column.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce_rise) begin
          rd_en   = 1'b1;
          col_d   = col_next(col_q, COL_LAST);
          state_d = (col_q == COL_LAST) ? WAIT_END : FETCH;
        end
      end
      FETCH: begin
        rd_en = 1'b1;
        col_d = col_next(col_q, COL_LAST);
        if (col_q == COL_LAST) begin
          state_d = WAIT_END;
        end
      end
      WAIT_END: begin
        if (!clk_en && !CE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shift counting, pixel capture, overrun and bank-swap bookkeeping.
  always_comb begin
    sh_d   = sh_q;
    rgb_d  = rgb_q;
    ovr_d  = ovr_q | over_cycle;
    bank_d = bank_q ^ swap_now;
    ack_d  = swap_now;
    pend_d = pend_q;
    if (state_q == IDLE && ce_rise) begin
      sh_d = '0;
    end else if (clk_en && in_row && sh_q != SH_FULL) begin
      sh_d = sh_q + SH_W'(1);
    end
    if (rd_en_q) begin
      rgb_d = rgb_t'(fb.fb_rd_data);
    end
    // A request coinciding with the qualifying LAT is consumed by it.
    if (swap_now) begin
      pend_d = 1'b0;
    end else if (swap_req) begin
      pend_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      // Held high in reset so a CE already high at release is not taken
      // as a row start; a fresh rise is required.
      ce_q    <= 1'b1;
      col_q   <= '0;
      sh_q    <= '0;
      bank_q  <= 1'b0;
      pend_q  <= 1'b0;
      rd_en_q <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      ce_q    <= CE;
      col_q   <= col_d;
      sh_q    <= sh_d;
      bank_q  <= bank_d;
      pend_q  <= pend_d;
      rd_en_q <= rd_en;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
      rgb_q   <= rgb_d;
    end
  end

  assign fb.fb_rd_en   = rd_en;
  assign fb.fb_rd_addr = rd_en ? {bank_q, row_addr, col_q} : '0;

  // Past the last column the panel sees black rather than a stale pixel.
  assign rgb      = over_cycle ? '0 : rgb_q;
  assign swap_ack = ack_q;
  assign overrun  = ovr_q;

  led_sclk_gate u_sclk_gate (
    .clk_i  (clk),
    .en_i   (shift_ok),
    .sclk_o (SCLK)
  );

endmodule

// File: tb/tb_led_row_shifter.sv
// Self-checking bench for led_row_shifter: a framebuffer model answers
// reads, expected addresses/pixels are queued as rows are driven and
// compared against what the DUT presents at each SCLK pulse.
module tb_led_row_shifter;
  import led_matrix_pkg::*;

  localparam int unsigned COLS  = LM_COLS;
  localparam int unsigned ROW_W = LM_ROW_W;
  localparam int unsigned AW    = 1 + ROW_W + LM_COL_W;
  localparam int          LATC  = CTRL_CE_LEAD + COLS;

  logic             clk = 1'b0;
  logic             rst;
  logic             CE;
  logic             clk_en;
  logic             LAT;
  logic             swap_req;
  logic [ROW_W-1:0] row_addr;
  logic [5:0]       rgb;
  logic             SCLK;
  logic             swap_ack;
  logic             overrun;

  led_row_shifter_if #(.ROW_W(ROW_W)) fbif ();

  led_row_shifter #(.COLS(COLS), .ROW_W(ROW_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .CE       (CE),
    .clk_en   (clk_en),
    .LAT      (LAT),
    .row_addr (row_addr),
    .swap_req (swap_req),
    .fb       (fbif),
    .rgb      (rgb),
    .SCLK     (SCLK),
    .swap_ack (swap_ack),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Framebuffer model: data valid one cycle after the strobe.
  logic [5:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (fbif.fb_rd_en === 1'b1) fbif.fb_rd_data <= mem[fbif.fb_rd_addr];
  end

  int unsigned   total = 0;
  int unsigned   bad   = 0;
  logic          bank_m;

  logic [AW-1:0] exp_addr [$];
  logic [5:0]    exp_rgb  [$];
  logic [AW-1:0] obs_addr [$];
  logic [5:0]    obs_rgb  [$];
  logic [5:0]    obs_ovr  [$];
  int            obs_ack  [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic fill_random;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 6'($urandom);
  endtask

  // Scoreboard push: expected reads and pixels for one row of bank_m.
  task automatic push_row_expect(input logic [ROW_W-1:0] row);
    logic [AW-1:0]       a;
    logic [LM_COL_W-1:0] col;
    exp_addr.delete();
    exp_rgb.delete();
    for (int k = 0; k < COLS; k++) begin
      col = k[LM_COL_W-1:0];
      a   = {bank_m, row, col};
      exp_addr.push_back(a);
      exp_rgb.push_back(mem[a]);
    end
  endtask

  // Controller sequence for one row; called and returns at posedge+1.
  task automatic run_row(input logic [ROW_W-1:0] row, input int n_en,
                         input int swap_c1, input int swap_c2, input int glitch_c);
    int ncyc;
    ncyc = CTRL_CE_LEAD + n_en + 2;
    obs_addr.delete();
    obs_rgb.delete();
    obs_ovr.delete();
    obs_ack.delete();
    row_addr = row;
    for (int c = 0; c < ncyc; c++) begin
      CE       = (c < CTRL_CE_LEAD + n_en - CTRL_CE_TAIL) && (c != glitch_c);
      clk_en   = (c >= CTRL_CE_LEAD) && (c < CTRL_CE_LEAD + n_en);
      LAT      = (c == CTRL_CE_LEAD + n_en);
      swap_req = (c == swap_c1) || (c == swap_c2);
      @(negedge clk);
      #1;
      if (fbif.fb_rd_en === 1'b1) obs_addr.push_back(fbif.fb_rd_addr);
      if (SCLK === 1'b1) obs_rgb.push_back(rgb);
      else if (clk_en) obs_ovr.push_back(rgb);
      if (swap_ack === 1'b1) obs_ack.push_back(c);
      @(posedge clk);
      #1;
    end
    CE = 1'b0; clk_en = 1'b0; LAT = 1'b0; swap_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; CE = 1'b1; clk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    total++; if (rgb !== 6'h00) begin bad++; $display("FAIL reset_rgb got=%h want=00", rgb); end
    total++; if (SCLK !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", SCLK); end
    total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", swap_ack); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (fbif.fb_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", fbif.fb_rd_en); end
    total++; if (fbif.fb_rd_addr !== '0) begin bad++; $display("FAIL reset_rd_addr got=%h want=0", fbif.fb_rd_addr); end
    CE = 1'b0; clk_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_row_basic;
    logic [AW-1:0] ea, oa;
    logic [5:0]    er, orr;
    fill_random();
    push_row_expect(3'd3);
    run_row(3'd3, COLS, -1, -1, -1);
    total++; if (obs_addr.size() != COLS) begin bad++; $display("FAIL basic_reads got=%0d want=%0d", obs_addr.size(), COLS); end
    total++; if (obs_rgb.size() != COLS) begin bad++; $display("FAIL basic_sclk got=%0d want=%0d", obs_rgb.size(), COLS); end
    for (int k = 0; k < COLS; k++) begin
      ea  = exp_addr.pop_front();
      er  = exp_rgb.pop_front();
      oa  = (obs_addr.size() > 0) ? obs_addr.pop_front() : 'x;
      orr = (obs_rgb.size() > 0) ? obs_rgb.pop_front() : 'x;
      total++; if (oa !== ea) begin bad++; $display("FAIL basic_addr[%0d] got=%h want=%h", k, oa, ea); end
      total++; if (orr !== er) begin bad++; $display("FAIL basic_rgb[%0d] got=%h want=%h", k, orr, er); end
    end
    total++; if (obs_ack.size() != 0) begin bad++; $display("FAIL basic_ack got=%0d want=0", obs_ack.size()); end
  endtask

  task automatic test_col_pattern;
    logic [AW-1:0] a;
    logic [5:0]    orr, want;
    for (int i = 0; i < (1 << AW); i++) begin
      a = i[AW-1:0];
      mem[i] = {1'b0, a[LM_COL_W-1:0]};
    end
    run_row(3'd5, COLS, -1, -1, -1);
    total++; if (obs_rgb.size() != COLS) begin bad++; $display("FAIL pattern_sclk got=%0d want=%0d", obs_rgb.size(), COLS); end
    for (int k = 0; k < COLS; k++) begin
      want = k[5:0];
      orr  = (obs_rgb.size() > 0) ? obs_rgb.pop_front() : 'x;
      total++; if (orr !== want) begin bad++; $display("FAIL pattern_rgb[%0d] got=%h want=%h", k, orr, want); end
    end
  endtask

  task automatic test_ce_glitch;
    logic [AW-1:0] ea, oa;
    logic [5:0]    er, orr;
    fill_random();
    push_row_expect(3'd6);
    run_row(3'd6, COLS, -1, -1, 5);
    total++; if (obs_addr.size() != COLS) begin bad++; $display("FAIL glitch_reads got=%0d want=%0d", obs_addr.size(), COLS); end
    for (int k = 0; k < COLS; k++) begin
      ea  = exp_addr.pop_front();
      er  = exp_rgb.pop_front();
      oa  = (obs_addr.size() > 0) ? obs_addr.pop_front() : 'x;
      orr = (obs_rgb.size() > 0) ? obs_rgb.pop_front() : 'x;
      total++; if (oa !== ea) begin bad++; $display("FAIL glitch_addr[%0d] got=%h want=%h", k, oa, ea); end
      total++; if (orr !== er) begin bad++; $display("FAIL glitch_rgb[%0d] got=%h want=%h", k, orr, er); end
    end
  endtask

  task automatic test_swap;
    logic [AW-1:0] ea, oa;
    logic [5:0]    er, orr;
    logic [ROW_W-1:0] r;
    fill_random();
    // Two requests in row 2: the second is absorbed by the pending flag.
    for (int ri = 2; ri <= 7; ri++) begin
      r = ri[ROW_W-1:0];
      push_row_expect(r);
      run_row(r, COLS, (ri == 2) ? 5 : -1, (ri == 2) ? 9 : -1, -1);
      for (int k = 0; k < COLS; k++) begin
        ea = exp_addr.pop_front();
        oa = (obs_addr.size() > 0) ? obs_addr.pop_front() : 'x;
        total++; if (oa !== ea) begin bad++; $display("FAIL swap_addr_r%0d[%0d] got=%h want=%h", ri, k, oa, ea); end
      end
      if (ri == 7) begin
        total++; if (obs_ack.size() != 1) begin bad++; $display("FAIL swap_ack_count got=%0d want=1", obs_ack.size()); end
        total++; if (obs_ack.size() > 0 && obs_ack[0] != LATC + 1) begin bad++; $display("FAIL swap_ack_cycle got=%0d want=%0d", obs_ack[0], LATC + 1); end
      end else begin
        total++; if (obs_ack.size() != 0) begin bad++; $display("FAIL swap_early_ack_r%0d got=%0d want=0", ri, obs_ack.size()); end
      end
    end
    bank_m = ~bank_m;
    push_row_expect(3'd0);
    run_row(3'd0, COLS, -1, -1, -1);
    total++; if (obs_addr.size() != COLS) begin bad++; $display("FAIL swap_row0_reads got=%0d want=%0d", obs_addr.size(), COLS); end
    for (int k = 0; k < COLS; k++) begin
      ea  = exp_addr.pop_front();
      er  = exp_rgb.pop_front();
      oa  = (obs_addr.size() > 0) ? obs_addr.pop_front() : 'x;
      orr = (obs_rgb.size() > 0) ? obs_rgb.pop_front() : 'x;
      total++; if (oa !== ea) begin bad++; $display("FAIL swap_row0_addr[%0d] got=%h want=%h", k, oa, ea); end
      total++; if (orr !== er) begin bad++; $display("FAIL swap_row0_rgb[%0d] got=%h want=%h", k, orr, er); end
    end
    // No request outstanding: the next frame end must not swap again.
    run_row(3'd7, COLS, -1, -1, -1);
    total++; if (obs_ack.size() != 0) begin bad++; $display("FAIL swap_absorbed_ack got=%0d want=0", obs_ack.size()); end
    total++; if (obs_addr.size() > 0 && obs_addr[0] !== {bank_m, 3'd7, 5'd0}) begin bad++; $display("FAIL swap_absorbed_addr got=%h want=%h", obs_addr[0], {bank_m, 3'd7, 5'd0}); end
  endtask

  task automatic test_overrun;
    logic [AW-1:0] ea, oa;
    logic [5:0]    er, orr;
    fill_random();
    mem[{bank_m, 3'd1, 5'd31}] = 6'h2A;
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_before got=%b want=0", overrun); end
    push_row_expect(3'd1);
    run_row(3'd1, COLS + 1, -1, -1, -1);
    total++; if (obs_rgb.size() != COLS) begin bad++; $display("FAIL overrun_sclk got=%0d want=%0d", obs_rgb.size(), COLS); end
    for (int k = 0; k < COLS; k++) begin
      ea  = exp_addr.pop_front();
      er  = exp_rgb.pop_front();
      oa  = (obs_addr.size() > 0) ? obs_addr.pop_front() : 'x;
      orr = (obs_rgb.size() > 0) ? obs_rgb.pop_front() : 'x;
      total++; if (oa !== ea) begin bad++; $display("FAIL overrun_addr[%0d] got=%h want=%h", k, oa, ea); end
      total++; if (orr !== er) begin bad++; $display("FAIL overrun_rgb[%0d] got=%h want=%h", k, orr, er); end
    end
    total++; if (obs_ovr.size() != 1) begin bad++; $display("FAIL overrun_extra_cycles got=%0d want=1", obs_ovr.size()); end
    total++; if (obs_ovr.size() > 0 && obs_ovr[0] !== 6'h00) begin bad++; $display("FAIL overrun_rgb33 got=%h want=00", obs_ovr[0]); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", overrun); end
    run_row(3'd2, COLS, -1, -1, -1);
    total++; if (obs_rgb.size() != COLS) begin bad++; $display("FAIL overrun_next_sclk got=%0d want=%0d", obs_rgb.size(), COLS); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_reset_mid_row;
    logic [AW-1:0] ea, oa;
    logic [5:0]    er, orr;
    int            nrd, nsclk;
    fill_random();
    row_addr = 3'd4;
    for (int c = 0; c < CTRL_CE_LEAD + 10; c++) begin
      CE = 1'b1; clk_en = (c >= CTRL_CE_LEAD);
      @(posedge clk);
      #1;
    end
    // Shift cycle 10: mid-row, SCLK high in the low phase.
    CE = 1'b1; clk_en = 1'b1;
    @(negedge clk);
    #1;
    total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL midrow_sclk_before got=%b want=1", SCLK); end
    total++; if (fbif.fb_rd_en !== 1'b1) begin bad++; $display("FAIL midrow_rd_before got=%b want=1", fbif.fb_rd_en); end
    rst = 1'b1;
    #1;
    total++; if (rgb !== 6'h00) begin bad++; $display("FAIL midrow_rgb got=%h want=00", rgb); end
    total++; if (SCLK !== 1'b0) begin bad++; $display("FAIL midrow_sclk got=%b want=0", SCLK); end
    total++; if (fbif.fb_rd_en !== 1'b0) begin bad++; $display("FAIL midrow_rd_en got=%b want=0", fbif.fb_rd_en); end
    total++; if (fbif.fb_rd_addr !== '0) begin bad++; $display("FAIL midrow_rd_addr got=%h want=0", fbif.fb_rd_addr); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midrow_overrun got=%b want=0", overrun); end
    total++; if (swap_ack !== 1'b0) begin bad++; $display("FAIL midrow_ack got=%b want=0", swap_ack); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bank_m = 1'b0;
    nrd = 0; nsclk = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (fbif.fb_rd_en === 1'b1) nrd++;
      if (SCLK === 1'b1) nsclk++;
      @(posedge clk);
      #1;
    end
    total++; if (nrd != 0) begin bad++; $display("FAIL after_rst_reads got=%0d want=0", nrd); end
    total++; if (nsclk != 0) begin bad++; $display("FAIL after_rst_sclk got=%0d want=0", nsclk); end
    CE = 1'b0; clk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_row_expect(3'd4);
    run_row(3'd4, COLS, -1, -1, -1);
    total++; if (obs_addr.size() != COLS) begin bad++; $display("FAIL rst_row_reads got=%0d want=%0d", obs_addr.size(), COLS); end
    for (int k = 0; k < COLS; k++) begin
      ea  = exp_addr.pop_front();
      er  = exp_rgb.pop_front();
      oa  = (obs_addr.size() > 0) ? obs_addr.pop_front() : 'x;
      orr = (obs_rgb.size() > 0) ? obs_rgb.pop_front() : 'x;
      total++; if (oa !== ea) begin bad++; $display("FAIL rst_row_addr[%0d] got=%h want=%h", k, oa, ea); end
      total++; if (orr !== er) begin bad++; $display("FAIL rst_row_rgb[%0d] got=%h want=%h", k, orr, er); end
    end
  endtask

  task automatic test_swap_at_lat;
    logic [AW-1:0] ea, oa;
    fill_random();
    push_row_expect(3'd7);
    run_row(3'd7, COLS, LATC, -1, -1);
    total++; if (obs_ack.size() != 1) begin bad++; $display("FAIL latswap_ack_count got=%0d want=1", obs_ack.size()); end
    total++; if (obs_ack.size() > 0 && obs_ack[0] != LATC + 1) begin bad++; $display("FAIL latswap_ack_cycle got=%0d want=%0d", obs_ack[0], LATC + 1); end
    bank_m = ~bank_m;
    push_row_expect(3'd0);
    run_row(3'd0, COLS, -1, -1, -1);
    total++; if (obs_addr.size() != COLS) begin bad++; $display("FAIL latswap_reads got=%0d want=%0d", obs_addr.size(), COLS); end
    for (int k = 0; k < COLS; k++) begin
      ea = exp_addr.pop_front();
      oa = (obs_addr.size() > 0) ? obs_addr.pop_front() : 'x;
      total++; if (oa !== ea) begin bad++; $display("FAIL latswap_addr[%0d] got=%h want=%h", k, oa, ea); end
    end
  endtask

  initial begin
    rst = 1'b1; CE = 1'b0; clk_en = 1'b0; LAT = 1'b0; swap_req = 1'b0;
    row_addr = '0; bank_m = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_row_basic();
    test_col_pattern();
    test_ce_glitch();
    test_swap();
    test_overrun();
    test_reset_mid_row();
    test_swap_at_lat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_row_shifter.md
LED_ROW_SHIFTER -- requirements
Module: led_row_shifter

Interface
REQ-001 SHALL have parameter COLS, default 32, meaning columns per panel row and the number of shifts per row.
REQ-002 SHALL have parameter ROW_W, default 3, meaning the width of the row address (8 scan rows; upper and lower half-panels driven together).
REQ-003 SHALL have port clk, input, width 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, width 1, the reset: asynchronous, active-high.
REQ-005 SHALL have port CE, input, width 1, the row-load window from the matrix controller.
REQ-006 SHALL have port clk_en, input, width 1, the shift window from the matrix controller (one column per cycle).
REQ-007 SHALL have port LAT, input, width 1, the latch pulse from the matrix controller.
REQ-008 SHALL have port row_addr, input, width ROW_W, the current scan row; stable from CE rise until LAT.
REQ-009 SHALL have port swap_req, input, width 1, a one-cycle request to switch the displayed framebuffer bank.
REQ-010 SHALL have port fb_rd_en, output, width 1, the framebuffer read strobe.
REQ-011 SHALL have port fb_rd_addr, output, width 1+ROW_W+5, addressing {bank, row, col}.
REQ-012 SHALL have port fb_rd_data, input, width 6, carrying {R1,G1,B1,R0,G0,B0}; it is valid exactly 1 cycle after fb_rd_en.
REQ-013 SHALL have port rgb, output, width 6, driving panel pins {R1,G1,B1,R0,G0,B0}.
REQ-014 SHALL have port SCLK, output, width 1, the panel shift clock.
REQ-015 SHALL have port swap_ack, output, width 1, a one-cycle pulse when the bank switch takes effect.
REQ-016 SHALL have port overrun, output, width 1, a sticky flag set when the shift window exceeds COLS cycles.

Function
REQ-017 SHALL detect a CE rising edge (CE=1, registered CE=0) and treat it as the start of a row.
REQ-018 SHALL use an FSM with states IDLE, FETCH and WAIT_END.
REQ-019 SHALL move IDLE->FETCH on CE rise.
REQ-020 SHALL move FETCH->WAIT_END after the read for col COLS-1 is issued.
REQ-021 SHALL move WAIT_END->IDLE when clk_en=0 and CE=0.
REQ-022 SHALL, in FETCH, assert fb_rd_en on every cycle, with fb_rd_addr={bank,row_addr,col_cnt} and col_cnt incrementing 0..COLS-1; the first read is issued in the CE-rise cycle itself.
REQ-023 SHALL load rgb from fb_rd_data in the cycle after each read (registered 1-cycle delay of fb_rd_en); rgb otherwise holds its value.
REQ-024 SHALL present column k on rgb during the k-th cycle of clk_en=1 (k=0..COLS-1), given the controller's 2-cycle CE-before-clk_en lead.
REQ-025 SHALL drive SCLK high during the low phase of clk in each cycle where clk_en=1 and the shift count is below COLS, so the panel samples mid-cycle on stable data; SCLK SHALL be 0 otherwise.
REQ-026 SHALL count clk_en cycles per row; a (COLS+1)-th clk_en cycle SHALL produce no SCLK pulse, drive rgb=0 and set overrun, which stays set until rst.
REQ-027 SHALL ignore a CE rise while not in IDLE, without restarting the fetch.
REQ-028 SHALL latch swap_req into swap_pending; a swap_req arriving while swap_pending=1 SHALL be absorbed.
REQ-029 SHALL, on LAT=1 with row_addr=2^ROW_W-1 and swap_pending=1, toggle bank, clear swap_pending and pulse swap_ack in the next cycle.
REQ-030 SHALL, if swap_req coincides with the qualifying LAT, apply the swap at that LAT.
REQ-031 SHALL never change bank mid-frame.
REQ-032 SHALL wrap col_cnt at COLS with no carry into the row field.

Reset
REQ-033 SHALL, while rst=1, force state=IDLE, col_cnt=0, shift count=0, bank=0, swap_pending=0, rgb=0, fb_rd_en=0, fb_rd_addr=0, SCLK=0, swap_ack=0, overrun=0.
REQ-034 SHALL, when rst is asserted mid-row, abandon the row immediately, and after release SHALL wait for a fresh CE rise.

Structure
REQ-035 SHALL take COLS, ROW_W, the FSM state encodings and the RGB bit-field positions from a shared package (led_matrix_pkg), alongside the controller's constants.
REQ-036 SHALL place the SCLK gating in one sub-module, led_sclk_gate, so it maps to a technology clock-gate/ODDR cell.
REQ-037 SHALL contain no other sub-modules.

Verification
REQ-038 SHALL pass this scenario: drive the controller sequence (CE 2 cycles, then 30 cycles CE+clk_en, then 2 cycles clk_en only, then LAT) with row_addr=3, bank 0 -> exactly 32 reads at addresses 0x060..0x07F, 32 SCLK pulses, and rgb in shift cycle k equal to the memory word at 0x060+k.
REQ-039 SHALL pass this scenario: a memory pattern where word = col[5:0] -> the sampled rgb sequence at the SCLK edges is 0,1,...,31 (0x1F masked to 6 bits) with no skipped or repeated column.
REQ-040 SHALL pass this scenario: swap_req during row 2 -> bank stays 0 through the row-7 LAT, swap_ack pulses one cycle after that LAT, and the next row-0 reads use addresses 0x100..0x11F.
REQ-041 SHALL pass this scenario: a clk_en window held for 33 cycles -> 32 SCLK pulses, rgb=0 in cycle 33, overrun=1 and staying 1 until rst.
REQ-042 SHALL pass this scenario: rst asserted at shift cycle 10 -> all outputs 0 asynchronously, and no reads until the next CE rise after release.
REQ-043 SHALL pass this scenario: a second CE rise injected during FETCH -> col_cnt unaffected and read count still 32.
